// File: rtl/ult_min_scan.sv
// Streaming minimum finder: scans LEN unsigned words and reports the smallest
// value together with its zero-based position (earliest position wins on ties).
`timescale 1ns/1ps
module ult_min_scan #(
  parameter  int WIDTH = 4,
  parameter  int LEN   = 8,
  localparam int IW    = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic [WIDTH-1:0] min_o,
  output logic [IW-1:0]    idx_o,
  output logic             min_valid_o,
  input  logic             min_ready_i,
  output logic             busy_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // SCAN  | accepting words, tracking running minimum and its position
  // DONE  | result presented, waiting for min_ready_i
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(LEN - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry;
  logic             lt;

  // Carry-out of data_i + ~min_q + 1; no carry means data_i < min_q.
  always_comb begin
    carry = 1'b1;
    for (int b = 0; b < WIDTH; b++) begin
      carry = (data_i[b] & ~min_q[b]) | (carry & (data_i[b] ^ ~min_q[b]));
    end
    lt = ~carry;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_SCAN;
          cnt_d   = '0;
        end
      end
      S_SCAN: begin
        if (data_valid_i) begin
          cnt_d = cnt_q + IW'(1);
          if ((cnt_q == '0) || lt) begin
            min_d = data_i;
            idx_d = cnt_q;
          end
          if (cnt_q == LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (min_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      min_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      idx_q   <= idx_d;
    end
  end

  assign data_ready_o = (state_q == S_SCAN);
  assign min_valid_o  = (state_q == S_DONE);
  assign busy_o       = (state_q != S_IDLE);
  assign min_o        = min_q;
  assign idx_o        = idx_q;

endmodule

// File: tb/tb_ult_min_scan.sv
// Bench for ult_min_scan: LEN=4 instance checked every cycle against a queue-based
// model under directed and random scans; LEN=2 instance swept over all word pairs.
`timescale 1ns/1ps
module tb_ult_min_scan;

  typedef int w4_t[4];

  logic       clk;
  logic       rst_n;

  logic       a_start, a_valid, a_ready, a_ovalid, a_oready, a_busy;
  logic [3:0] a_data, a_min;
  logic [1:0] a_idx;

  logic       b_start, b_valid, b_ready, b_ovalid, b_oready, b_busy;
  logic [3:0] b_data, b_min;
  logic [0:0] b_idx;

  int total_checks;
  int passed_checks;

  ult_min_scan #(.WIDTH(4), .LEN(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start_i(a_start), .data_i(a_data),
    .data_valid_i(a_valid), .data_ready_o(a_ready), .min_o(a_min), .idx_o(a_idx),
    .min_valid_o(a_ovalid), .min_ready_i(a_oready), .busy_o(a_busy)
  );

  ult_min_scan #(.WIDTH(4), .LEN(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start_i(b_start), .data_i(b_data),
    .data_valid_i(b_valid), .data_ready_o(b_ready), .min_o(b_min), .idx_o(b_idx),
    .min_valid_o(b_ovalid), .min_ready_i(b_oready), .busy_o(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int exp);
    total_checks++;
    if (got == exp) passed_checks++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Model for instance A: phase 0 = idle, 1 = collecting words, 2 = result held.
  int m_phase;
  int m_words[$];
  int m_min;
  int m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_words.delete();
      m_min = 0;
      m_idx = 0;
    end else begin
      case (m_phase)
        0: if (a_start) begin
             m_phase = 1;
             m_words.delete();
           end
        1: if (a_valid) begin
             m_words.push_back(int'(a_data));
             if (m_words.size() == 4) begin
               m_min = m_words[0];
               m_idx = 0;
               for (int j = 1; j < 4; j++) begin
                 if (m_words[j] < m_min) begin
                   m_min = m_words[j];
                   m_idx = j;
                 end
               end
               m_phase = 2;
             end
           end
        default: if (a_oready) m_phase = 0;
      endcase
    end
  end

  // The running minimum is internal while collecting, so value/index are compared elsewhere.
  always @(negedge clk) begin
    chk("a_ready", int'(a_ready), int'(m_phase == 1));
    chk("a_ovalid", int'(a_ovalid), int'(m_phase == 2));
    chk("a_busy", int'(a_busy), int'(m_phase != 0));
    if (m_phase != 1) begin
      chk("a_min", int'(a_min), m_min);
      chk("a_idx", int'(a_idx), m_idx);
    end
  end

  task automatic send_a(input int w, input bit noise);
    int n;
    a_data  = 4'(w);
    a_valid = 1'b1;
    n = 0;
    while (!a_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("a_ready_timeout", 0, 1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    a_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic wait_valid_a();
    int n;
    n = 0;
    while (!a_ovalid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("a_ovalid_timeout", 0, 1);
  endtask

  task automatic scan_a(input w4_t w, input int gap, input int hold, input bit noise);
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_a(w[i], noise);
      if (i < 3) begin
        repeat (gap) begin
          a_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          @(posedge clk); #1;
        end
      end
    end
    chk("latency_ovalid", int'(a_ovalid), 1);
    wait_valid_a();
    repeat (hold) begin
      a_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
    end
    a_start  = 1'b0;
    a_oready = 1'b1;
    @(posedge clk); #1;
    a_oready = 1'b0;
  endtask

  initial begin
    w4_t w;
    total_checks  = 0;
    passed_checks = 0;
    rst_n    = 1'b0;
    a_start  = 1'b0; a_valid = 1'b0; a_data = '0; a_oready = 1'b0;
    b_start  = 1'b0; b_valid = 1'b0; b_data = '0; b_oready = 1'b0;
    #1;
    chk("reset_busy", int'(a_busy), 0);
    chk("reset_ovalid", int'(a_ovalid), 0);
    chk("reset_min", int'(a_min), 0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    w = '{9, 3, 7, 5};
    scan_a(w, 0, 0, 1'b0);
    chk("basic_min", int'(a_min), 3);
    chk("basic_idx", int'(a_idx), 1);
    chk("model_basic_min", m_min, 3);

    w = '{6, 2, 2, 8};
    scan_a(w, 0, 1, 1'b0);
    chk("tie_min", int'(a_min), 2);
    chk("tie_idx", int'(a_idx), 1);
    chk("model_tie_idx", m_idx, 1);

    w = '{15, 15, 15, 15};
    scan_a(w, 0, 0, 1'b0);
    chk("max_min", int'(a_min), 15);
    chk("max_idx", int'(a_idx), 0);

    w = '{4, 5, 6, 0};
    scan_a(w, 0, 0, 1'b0);
    chk("zero_min", int'(a_min), 0);
    chk("zero_idx", int'(a_idx), 3);

    w = '{9, 3, 7, 5};
    scan_a(w, 3, 5, 1'b1);
    chk("stall_min", int'(a_min), 3);
    chk("stall_idx", int'(a_idx), 1);

    // Reset in the middle of a scan, then a fresh start right after release.
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    send_a(9, 1'b0);
    send_a(3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(a_busy), 0);
    chk("midrst_ready", int'(a_ready), 0);
    chk("midrst_ovalid", int'(a_ovalid), 0);
    chk("midrst_min", int'(a_min), 0);
    chk("midrst_idx", int'(a_idx), 0);
    rst_n   = 1'b1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    chk("post_rst_start", int'(a_ready), 1);
    for (int i = 0; i < 4; i++) send_a(1, 1'b0);
    wait_valid_a();
    chk("post_rst_min", int'(a_min), 1);
    chk("post_rst_idx", int'(a_idx), 0);
    a_oready = 1'b1;
    @(posedge clk); #1;
    a_oready = 1'b0;

    // Back-to-back scans with start held high.
    a_start  = 1'b1;
    a_oready = 1'b1;
    @(posedge clk); #1;
    send_a(5, 1'b0); send_a(6, 1'b0); send_a(7, 1'b0); send_a(8, 1'b0);
    a_start = 1'b1;
    chk("b2b_first_valid", int'(a_ovalid), 1);
    chk("b2b_first_min", int'(a_min), 5);
    @(posedge clk); #1;
    chk("b2b_idle_busy", int'(a_busy), 0);
    @(posedge clk); #1;
    chk("b2b_rescan_ready", int'(a_ready), 1);
    send_a(8, 1'b0); send_a(12, 1'b0); send_a(1, 1'b0); send_a(1, 1'b0);
    a_start = 1'b1;
    chk("b2b_second_valid", int'(a_ovalid), 1);
    chk("b2b_second_min", int'(a_min), 1);
    chk("b2b_second_idx", int'(a_idx), 2);
    a_start = 1'b0;
    @(posedge clk); #1;
    a_oready = 1'b0;
    @(posedge clk); #1;
    chk("b2b_hold_min", int'(a_min), 1);
    chk("b2b_hold_idx", int'(a_idx), 2);

    // Random scans; tie-heavy words half of the time.
    for (int s = 0; s < 150; s++) begin
      for (int i = 0; i < 4; i++)
        w[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      scan_a(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b1);
    end

    // Exhaustive pair sweep on the two-word instance.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        chk($sformatf("pair_ready %0d,%0d", a, b), int'(b_ready), 1);
        b_valid = 1'b1;
        b_data  = 4'(a);
        @(posedge clk); #1;
        b_data  = 4'(b);
        @(posedge clk); #1;
        b_valid = 1'b0;
        chk($sformatf("pair_valid %0d,%0d", a, b), int'(b_ovalid), 1);
        chk($sformatf("pair_idx %0d,%0d", a, b), int'(b_idx), (b < a) ? 1 : 0);
        chk($sformatf("pair_min %0d,%0d", a, b), int'(b_min), (b < a) ? b : a);
        b_oready = 1'b1;
        @(posedge clk); #1;
        b_oready = 1'b0;
        chk($sformatf("pair_idle %0d,%0d", a, b), int'(b_busy), 0);
      end
    end

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed_checks, total_checks);
    $fatal(1);
  end

endmodule

// File: doc/ult_min_scan.md
ULT_MIN_SCAN -- requirements
Module: ult_min_scan

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits (1..16).
REQ-002 Parameter LEN, default 8, words per scan (2..256).
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RESETN  input  1  reset, asynchronous and active-low.
REQ-005 START  input  1  request a new scan; sampled only in IDLE.
REQ-006 I  input  WIDTH  unsigned data word.
REQ-007 I_VALID  input  1  I holds a valid word.
REQ-008 I_READY  output  1  block accepts I this cycle.
REQ-009 O  output  WIDTH  minimum value found by the scan.
REQ-010 IDX  output  max(1,clog2(LEN))  zero-based position of O within the scan.
REQ-011 O_VALID  output  1  O and IDX hold a completed result.
REQ-012 O_READY  input  1  consumer accepts the result.
REQ-013 BUSY  output  1  high in SCAN or DONE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-015 IDLE: I_READY=0, O_VALID=0, BUSY=0; START=1 -> SCAN next cycle, word counter cleared.
REQ-016 SCAN: I_READY=1, BUSY=1, O_VALID=0; a transfer occurs on a cycle with I_VALID=1 and I_READY=1.
REQ-017 No transfer in SCAN (I_VALID=0) SHALL leave all state unchanged; gaps of any length are legal.
REQ-018 Transfer 0 SHALL load I into the running minimum and 0 into the running index unconditionally.
REQ-019 Transfer k>0 SHALL replace the minimum with I and the index with k only when I is strictly less than the current minimum (unsigned).
REQ-020 On equal values the earliest index SHALL be kept.
REQ-021 The less-than decision SHALL be computed as NOT carry-out of I + ~min + 1 over WIDTH bits, i.e. one shared subtract-with-carry comparator, no other magnitude comparator.
REQ-022 The word counter SHALL increment once per transfer. On transfer LEN-1 the FSM SHALL enter DONE on the next edge.
REQ-023 Latency: O_VALID SHALL rise in the cycle immediately after the LEN-th transfer, with O/IDX already final.
REQ-024 DONE: I_READY=0, O_VALID=1, BUSY=1; O and IDX SHALL remain stable until the handshake.
REQ-025 DONE with O_READY=1 -> IDLE next cycle; O_VALID SHALL drop, O and IDX SHALL hold their last values.
REQ-026 START SHALL be ignored in SCAN and DONE; it has no queued effect.
REQ-027 START=1 held continuously SHALL start a new scan on the cycle after each return to IDLE.
REQ-028 O and IDX SHALL be driven only from registers; no combinational path from I to O/IDX.

Reset
REQ-029 RESETN=0 SHALL immediately, without a clock edge, force: state IDLE, counter 0, O=0, IDX=0, O_VALID=0, I_READY=0, BUSY=0.
REQ-030 Reset asserted mid-SCAN or in DONE SHALL discard the partial or pending result; no result is emitted later.
REQ-031 After RESETN rises, the first START SHALL be honoured on the next rising edge.

Verification (WIDTH=4, LEN=4)
REQ-032 START, then words 9,3,7,5 back-to-back -> O_VALID=1 one cycle after 4th transfer, O=3, IDX=1.
REQ-033 Ties and extremes: 6,2,2,8 -> O=2, IDX=1; 15,15,15,15 -> O=15, IDX=0; 4,5,6,0 -> O=0, IDX=3.
REQ-034 Stalls: words 9,3,7,5 with I_VALID low 3 cycles between each word; O_READY held low 5 cycles in DONE -> same result as REQ-032; O_VALID, O and IDX stable throughout; START pulses during SCAN/DONE have no effect.
REQ-035 Reset mid-scan: RESETN pulsed low after 2 transfers -> all outputs 0 asynchronously, state IDLE; new scan 1,1,1,1 -> O=1, IDX=0.
REQ-036 Back-to-back scans: START held high and O_READY=1 -> IDLE lasts exactly one cycle between scans; second scan 8,12,1,1 -> O=1, IDX=2, independent of the first scan's result.
REQ-037 Comparator boundary: every pair (a,b) in 0..15 fed as 2-word scans (LEN=2) -> IDX=1 exactly when b<a.
